eth_tx_arb: RTL and testbench
=============================

# eth_tx_arb

Frame-level two-source arbiter for the 10G Ethernet MAC TX AXI4-Stream port, in the `clk156` domain. It sits between the TX requesters and the MAC `s_axis_tx_*` input. Source 0 is the TLP encapsulator output and source 1 is the test-frame generator. Once a source wins, the MAC is locked to it until the frame's `tlast`. It then enforces a programmable idle gap and round-robins between sources, and it counts the frames forwarded from each source.

## Interface
Parameters:
- `IFG_CYCLES`, default 8: idle cycles forced on the output after each frame; legal range 0..255.
- `DATA_WIDTH`, default 64: tdata width.
- `KEEP_WIDTH`, default `DATA_WIDTH/8`: tkeep width.

Ports:
- `clk156` in 1: 156.25 MHz MAC core clock. Single clock domain.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `en0`, `en1` in 1: source enables. These are sampled only at arbitration.
- `s0_axis_tvalid`/`tready`/`tdata`/`tkeep`/`tlast`/`tuser`: in/out/in/in/in/in, widths 1/1/DATA_WIDTH/KEEP_WIDTH/1/1. Source 0 stream.
- `s1_axis_*`: same as `s0_axis_*`. Source 1 stream.
- `m_axis_tvalid`/`tready`/`tdata`/`tkeep`/`tlast`/`tuser`: out/in/out/out/out/out, same widths. Connects to the MAC TX port.
- `busy` out 1: high in GRANT state.
- `grant` out 1: index of the current or last-served source.
- `frame_cnt0`, `frame_cnt1` out 32: frames completed per source.

## Operation
- States: IDLE, GRANT, GAP.
- **Reset:** state=IDLE, `grant`=1 (so source 0 is preferred first), gap counter=0, `frame_cnt0`=`frame_cnt1`=0, `busy`=0.
- **Outputs in IDLE and GAP:** `m_axis_tvalid`=0, `s0_axis_tready`=`s1_axis_tready`=0. `m_axis_tdata`/`tkeep`/`tlast`/`tuser` are driven 0.
- **Requests:** req0 = `s0_axis_tvalid & en0`, req1 = `s1_axis_tvalid & en1`.
- **IDLE:**
  - Only one request: grant that source.
  - Both requests: grant `~grant` (round-robin).
  - No request: stay in IDLE.
  - On a grant, register `grant` and move to GRANT.
- **GRANT:**
  - Combinational passthrough of the granted source: `m_axis_{tvalid,tdata,tkeep,tlast,tuser}` = granted `s*`, and granted `s*_tready` = `m_axis_tready`.
  - Non-granted tready = 0.
  - No registers in the data path.
- **End of frame:** a beat with `m_axis_tvalid & m_axis_tready & m_axis_tlast` increments the granted `frame_cnt`.
  - `IFG_CYCLES`>0: next state GAP, gap counter loaded with `IFG_CYCLES-1`.
  - `IFG_CYCLES`=0: next state IDLE.
- **GAP:** decrement the counter each cycle; go to IDLE when the counter is 0 in that cycle.
- **Frame lock:** the arbiter switches sources only between frames.
  - Deasserting `en*` or the requester's tvalid mid-frame does not abort the frame; GRANT holds and the output tvalid simply follows the source.
  - A tuser=1 (error) beat is forwarded unchanged and is still counted as a frame.
- **Counters:** 32-bit, wrap from 0xFFFFFFFF to 0 with no saturation.
- **Reset mid-frame:** all state returns to reset values immediately (asynchronous). The partial frame is dropped from the arbiter's view, and the source must restart its frame.

## Timing
- Arbitration latency: a request first seen in IDLE in cycle N is granted on the edge ending N. The first beat can transfer in cycle N+1.
- Minimum inter-frame spacing at the output:
  - `tlast` accepted in cycle T.
  - GAP occupies cycles T+1..T+IFG_CYCLES.
  - IDLE is cycle T+IFG_CYCLES+1.
  - Next first beat is no earlier than T+IFG_CYCLES+2.
  - So the output shows `IFG_CYCLES`+1 idle cycles. With `IFG_CYCLES`=0 there is exactly 1 idle cycle.
- Single-beat frame (`tlast` on the first beat): legal. GRANT lasts one cycle if tready=1.
- Backpressure: while `m_axis_tready`=0 in GRANT, the granted tready=0 and the source must hold its beat stable (AXIS rules). The state is unchanged.
- Counter update is visible the cycle after the `tlast` beat.
- `busy` and `grant` are registered; they change on the same edge as the state.

## Test plan
- **Reset values:** assert `sys_rst_n`=0 mid-stream -> all treadys, `m_axis_tvalid`, `busy` and the counters read 0 in the same cycle; after release, `grant`=1.
- **Single source:** source 0 only, `IFG_CYCLES`=8, 3-beat frame with tready=1 -> beats appear in cycles N+1..N+3, then 9 idle cycles, then `frame_cnt0`=1.
- **Round-robin:**
  - Both sources continuously valid, 2-beat frames -> output order is s0, s1, s0, s1.
  - After 4 frames, `frame_cnt0`=`frame_cnt1`=2.
  - The non-granted source's tready never goes high.
- **Frame lock under backpressure:**
  - Toggle `m_axis_tready` randomly and drop `en0` mid-frame -> the source-0 frame completes intact with the beat count preserved.
  - Source 1 is then granted with no idle beyond the gap.
- **Boundaries:**
  - `IFG_CYCLES`=0 with back-to-back single-beat frames -> exactly 1 idle cycle between frames.
  - A tuser=1 frame is forwarded and counted.
  - Preload `frame_cnt1` to 0xFFFFFFFF via force -> the next frame wraps it to 0.

Source files
------------

// File: rtl/eth_tx_arb_if.sv
// eth_tx_arb_if: AXI4-Stream bundle for the Ethernet MAC TX path.
//   tvalid/tdata/tkeep/tlast/tuser travel from master to slave.
//   tready travels back from slave to master.
//   master modport: the side that produces beats.
//   slave modport:  the side that consumes beats.
interface eth_tx_arb_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
    logic                  tuser;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/eth_tx_arb.sv
// eth_tx_arb: frame-level two-source arbiter in front of the 10G MAC TX port.
// Source 0 is the TLP encapsulator and source 1 is the test-frame generator.
// Once a source is granted, the output stays locked to it until tlast.
// After each frame the block forces an idle gap of IFG_CYCLES cycles.
// Ties are broken round-robin, and completed frames are counted per source.
//
// Ports:
//   clk156, sys_rst_n  : clock, and asynchronous active-low reset.
//   en0, en1           : source enables, sampled only while arbitrating.
//   s0_axis, s1_axis   : source streams (slave side).
//   m_axis             : stream toward the MAC (master side).
//   busy               : high while a frame is granted.
//   grant              : current or last-served source index.
//   frame_cnt0/1       : completed frames per source, wrapping at 32 bits.
module eth_tx_arb #(
    parameter int IFG_CYCLES = 8,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                clk156,
    input  logic                sys_rst_n,
    input  logic                en0,
    input  logic                en1,
    eth_tx_arb_if.slave         s0_axis,
    eth_tx_arb_if.slave         s1_axis,
    eth_tx_arb_if.master        m_axis,
    output logic                busy,
    output logic                grant,
    output logic [31:0]         frame_cnt0,
    output logic [31:0]         frame_cnt1
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    // The counter is loaded on the tlast beat, so GAP lasts exactly IFG_CYCLES cycles.
    localparam logic [7:0] GAP_LOAD = (IFG_CYCLES > 0) ? 8'(IFG_CYCLES - 1) : 8'd0;

    state_t     state;
    logic [7:0] gap_cnt;

    logic req0, req1;
    logic sel_valid, sel_last, eof;

    assign req0 = s0_axis.tvalid & en0;
    assign req1 = s1_axis.tvalid & en1;

    assign sel_valid = grant ? s1_axis.tvalid : s0_axis.tvalid;
    assign sel_last  = grant ? s1_axis.tlast  : s0_axis.tlast;
    assign eof       = (state == GRANT) & sel_valid & m_axis.tready & sel_last;

    // Pure combinational passthrough while granted.
    // Everything is held quiet in IDLE and GAP.
    always_comb begin
        m_axis.tvalid  = 1'b0;
        m_axis.tdata   = '0;
        m_axis.tkeep   = '0;
        m_axis.tlast   = 1'b0;
        m_axis.tuser   = 1'b0;
        s0_axis.tready = 1'b0;
        s1_axis.tready = 1'b0;
        if (state == GRANT) begin
            if (grant) begin
                m_axis.tvalid  = s1_axis.tvalid;
                m_axis.tdata   = s1_axis.tdata;
                m_axis.tkeep   = s1_axis.tkeep;
                m_axis.tlast   = s1_axis.tlast;
                m_axis.tuser   = s1_axis.tuser;
                s1_axis.tready = m_axis.tready;
            end else begin
                m_axis.tvalid  = s0_axis.tvalid;
                m_axis.tdata   = s0_axis.tdata;
                m_axis.tkeep   = s0_axis.tkeep;
                m_axis.tlast   = s0_axis.tlast;
                m_axis.tuser   = s0_axis.tuser;
                s0_axis.tready = m_axis.tready;
            end
        end
    end

    // grant resets to 1, so the first contested arbitration goes to source 0.
    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            grant      <= 1'b1;
            busy       <= 1'b0;
            gap_cnt    <= '0;
            frame_cnt0 <= '0;
            frame_cnt1 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        grant <= (req0 & req1) ? ~grant : req1;
                        busy  <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    // Enables and source tvalid are ignored here.
                    // Only tlast releases the lock.
                    if (eof) begin
                        if (grant) frame_cnt1 <= frame_cnt1 + 32'd1;
                        else       frame_cnt0 <= frame_cnt0 + 32'd1;
                        busy <= 1'b0;
                        if (IFG_CYCLES > 0) begin
                            gap_cnt <= GAP_LOAD;
                            state   <= GAP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 8'd0) state <= IDLE;
                    else                 gap_cnt <= gap_cnt - 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_arb.sv
module tb_eth_tx_arb;

    logic clk156 = 1'b0;
    logic sys_rst_n = 1'b0;
    logic en0 = 1'b0, en1 = 1'b0;
    logic busy, grant;
    logic [31:0] frame_cnt0, frame_cnt1;

    logic b_en0 = 1'b1, b_en1 = 1'b0;
    logic b_busy, b_grant;
    logic [31:0] b_cnt0, b_cnt1;

    always #5 clk156 = ~clk156;

    eth_tx_arb_if #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) s0_if ();
    eth_tx_arb_if #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) s1_if ();
    eth_tx_arb_if #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) m_if ();
    eth_tx_arb_if #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) b0_if ();
    eth_tx_arb_if #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) b1_if ();
    eth_tx_arb_if #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) bm_if ();

    eth_tx_arb #(.IFG_CYCLES(8), .DATA_WIDTH(64), .KEEP_WIDTH(8)) dut (
        .clk156(clk156), .sys_rst_n(sys_rst_n), .en0(en0), .en1(en1),
        .s0_axis(s0_if), .s1_axis(s1_if), .m_axis(m_if),
        .busy(busy), .grant(grant), .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1));

    eth_tx_arb #(.IFG_CYCLES(0), .DATA_WIDTH(64), .KEEP_WIDTH(8)) dut_b (
        .clk156(clk156), .sys_rst_n(sys_rst_n), .en0(b_en0), .en1(b_en1),
        .s0_axis(b0_if), .s1_axis(b1_if), .m_axis(bm_if),
        .busy(b_busy), .grant(b_grant), .frame_cnt0(b_cnt0), .frame_cnt1(b_cnt1));

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
    } beat_t;

    beat_t sb[$];
    int    b_hs[$];
    int    n_cmp = 0, n_err = 0;
    int    cyc = 0;
    bit    sb_on = 1'b1, bp_on = 1'b0, prev_last = 1'b1;
    int    first_cyc = 0, tlast_cyc = 0, gap_obs = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_data(input int src, input int fid, input int b);
        return {8'(src), 8'(fid), 8'(b), 40'h5A5A5A5A5A};
    endfunction

    // Expected output beats, pushed in the order the arbiter should emit them.
    task automatic expect_frame(input int src, input int fid, input int nb, input bit usr);
        beat_t e;
        for (int b = 0; b < nb; b++) begin
            e.d = mk_data(src, fid, b);
            e.l = (b == nb - 1);
            e.k = e.l ? 8'h0F : 8'hFF;
            e.u = e.l & usr;
            sb.push_back(e);
        end
    endtask

    task automatic drive(input int src, input logic v, input logic [63:0] d,
                         input logic [7:0] k, input logic l, input logic u);
        if (src == 0) begin
            s0_if.tvalid = v; s0_if.tdata = d; s0_if.tkeep = k; s0_if.tlast = l; s0_if.tuser = u;
        end else begin
            s1_if.tvalid = v; s1_if.tdata = d; s1_if.tkeep = k; s1_if.tlast = l; s1_if.tuser = u;
        end
    endtask

    // AXIS source: holds each beat until handshake.
    // It may drop its own enable at beat drop_at.
    task automatic send(input int src, input int fid, input int nb, input bit usr, input int drop_at);
        bit hs;
        int waited;
        for (int b = 0; b < nb; b++) begin
            if (b == drop_at) begin
                if (src == 0) en0 = 1'b0; else en1 = 1'b0;
            end
            drive(src, 1'b1, mk_data(src, fid, b), (b == nb - 1) ? 8'h0F : 8'hFF,
                  (b == nb - 1), (b == nb - 1) & usr);
            hs = 1'b0;
            waited = 0;
            while (!hs) begin
                @(negedge clk156);
                hs = (src == 0) ? (s0_if.tvalid & s0_if.tready) : (s1_if.tvalid & s1_if.tready);
                @(posedge clk156); #1;
                if (!hs && ++waited > 300) begin
                    chk("send_timeout", 64'(src), 64'hFF);
                    drive(src, 1'b0, '0, '0, 1'b0, 1'b0);
                    return;
                end
            end
        end
        drive(src, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    always @(posedge clk156) cyc <= cyc + 1;

    always @(posedge clk156) begin
        #1;
        if (bp_on) m_if.tready = 1'($urandom_range(0, 1));
    end

    // Output monitor: scoreboard pop, inter-frame timing, and tready exclusivity.
    always @(negedge clk156) begin
        if (sys_rst_n) begin
            chk("tready_excl", 64'(s0_if.tready & s1_if.tready), 64'd0);
            if (!busy)
                chk("idle_quiet", {58'd0, m_if.tvalid, |m_if.tdata, m_if.tlast, m_if.tuser,
                                   s0_if.tready, s1_if.tready}, 64'd0);
        end
        if (m_if.tvalid && m_if.tready) begin
            if (sb_on) begin
                if (sb.size() == 0) chk("unexpected_beat", m_if.tdata, 64'hDEAD);
                else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("tdata", m_if.tdata, e.d);
                    chk("tkeep", 64'(m_if.tkeep), 64'(e.k));
                    chk("tlast", 64'(m_if.tlast), 64'(e.l));
                    chk("tuser", 64'(m_if.tuser), 64'(e.u));
                end
            end
            if (prev_last) begin
                gap_obs   = cyc - tlast_cyc - 1;
                first_cyc = cyc;
            end
            prev_last = m_if.tlast;
            if (m_if.tlast) tlast_cyc = cyc;
        end
    end

    always @(negedge clk156)
        if (bm_if.tvalid && bm_if.tready) b_hs.push_back(cyc);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0, 1'b0);
        m_if.tready = 1'b1;
        b0_if.tvalid = 1'b0; b0_if.tdata = 64'h0B0B; b0_if.tkeep = 8'hFF; b0_if.tlast = 1'b1; b0_if.tuser = 1'b0;
        b1_if.tvalid = 1'b0; b1_if.tdata = '0; b1_if.tkeep = '0; b1_if.tlast = 1'b0; b1_if.tuser = 1'b0;
        bm_if.tready = 1'b1;

        // Reset values
        #23;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant), 64'd1);
        chk("rst_cnt0", 64'(frame_cnt0), 64'd0);
        chk("rst_mvalid", 64'(m_if.tvalid), 64'd0);
        @(posedge clk156); #1;
        sys_rst_n = 1'b1;
        en0 = 1'b1; en1 = 1'b1;
        repeat (2) @(posedge clk156);
        #1;

        // Single source, 3 beats: beats land in N+1..N+3, followed by 9 idle cycles.
        n0 = cyc;
        expect_frame(0, 0, 3, 1'b0);
        send(0, 0, 3, 1'b0, -1);
        chk("ss_first_cyc", 64'(first_cyc), 64'(n0 + 1));
        chk("ss_last_cyc", 64'(tlast_cyc), 64'(n0 + 3));
        chk("ss_cnt0_1", 64'(frame_cnt0), 64'd1);
        expect_frame(0, 1, 3, 1'b0);
        send(0, 1, 3, 1'b0, -1);
        chk("ss_gap", 64'(gap_obs), 64'd9);
        chk("ss_cnt0_2", 64'(frame_cnt0), 64'd2);

        // A tuser (error) frame is forwarded and still counted.
        expect_frame(1, 0, 2, 1'b1);
        send(1, 0, 2, 1'b1, -1);
        chk("err_cnt1", 64'(frame_cnt1), 64'd1);
        chk("err_cnt0", 64'(frame_cnt0), 64'd2);

        // Reset mid-frame: outputs and counters clear asynchronously.
        sb_on = 1'b0;
        drive(0, 1'b1, 64'h1234, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 40 && !(busy && s0_if.tready); i++) @(negedge clk156);
        chk("mid_busy_pre", 64'(busy & s0_if.tready), 64'd1);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("mid_tready0", 64'(s0_if.tready), 64'd0);
        chk("mid_tready1", 64'(s1_if.tready), 64'd0);
        chk("mid_mvalid", 64'(m_if.tvalid), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_cnt0", 64'(frame_cnt0), 64'd0);
        chk("mid_cnt1", 64'(frame_cnt1), 64'd0);
        drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
        @(posedge clk156); #1;
        sys_rst_n = 1'b1;
        @(posedge clk156); #1;
        chk("post_rst_grant", 64'(grant), 64'd1);
        prev_last = 1'b1;
        sb_on = 1'b1;

        // Round-robin with both sources continuously valid.
        expect_frame(0, 2, 2, 1'b0);
        expect_frame(1, 1, 2, 1'b0);
        expect_frame(0, 3, 2, 1'b0);
        expect_frame(1, 2, 2, 1'b0);
        fork
            begin send(0, 2, 2, 1'b0, -1); send(0, 3, 2, 1'b0, -1); end
            begin send(1, 1, 2, 1'b0, -1); send(1, 2, 2, 1'b0, -1); end
        join
        chk("rr_cnt0", 64'(frame_cnt0), 64'd2);
        chk("rr_cnt1", 64'(frame_cnt1), 64'd2);

        // Frame lock under random backpressure.
        // en0 drops mid-frame, then source 1 follows after the gap.
        bp_on = 1'b1;
        expect_frame(0, 4, 5, 1'b0);
        expect_frame(1, 3, 2, 1'b0);
        fork
            begin send(0, 4, 5, 1'b0, 2); bp_on = 1'b0; m_if.tready = 1'b1; end
            begin send(1, 3, 2, 1'b0, -1); end
        join
        chk("bp_gap", 64'(gap_obs), 64'd9);
        chk("bp_cnt0", 64'(frame_cnt0), 64'd3);
        chk("bp_cnt1", 64'(frame_cnt1), 64'd3);
        en0 = 1'b1;

        // Counter wrap.
        force dut.frame_cnt1 = 32'hFFFFFFFF;
        @(negedge clk156);
        release dut.frame_cnt1;
        @(posedge clk156); #1;
        expect_frame(1, 4, 1, 1'b0);
        send(1, 4, 1, 1'b0, -1);
        chk("wrap_cnt1", 64'(frame_cnt1), 64'd0);
        chk("wrap_cnt0", 64'(frame_cnt0), 64'd3);
        repeat (3) @(posedge clk156);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);

        // With IFG_CYCLES=0, back-to-back single-beat frames leave exactly 1 idle cycle.
        b0_if.tvalid = 1'b1;
        for (int i = 0; i < 60 && b_hs.size() < 4; i++) begin
            @(posedge clk156); #1;
        end
        b0_if.tvalid = 1'b0;
        chk("ifg0_frames", 64'(b_hs.size()), 64'd4);
        if (b_hs.size() >= 4)
            for (int i = 1; i < 4; i++) chk("ifg0_spacing", 64'(b_hs[i] - b_hs[i-1]), 64'd2);
        repeat (3) @(posedge clk156);
        #1;
        chk("ifg0_cnt0", 64'(b_cnt0), 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
